// File: rtl/nonce_dispatch.sv
// Nonce issue sequencer for the Blake2b pipeline: one nonce per cycle, drain, report.
// Optional per-job nonce striding is compiled in with NONCE_STRIDE_EN.
module nonce_dispatch #(
  parameter int PIPE_LAT = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] m04_hi,
  input  logic [31:0] nonce_start,
  input  logic [31:0] nonce_end,
`ifdef NONCE_STRIDE_EN
  input  logic [7:0]  stride,
`endif
  input  logic        found,
  output logic        valid,
  output logic [63:0] m04,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [31:0] hash_cnt
);

  localparam int DW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   hi_q, hi_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          valid_q, valid_d;
  logic [63:0]   m04_q, m04_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          hit_q, hit_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   step;

`ifdef NONCE_STRIDE_EN
  logic [7:0] stride_q, stride_d;
  // A latched stride of 0 would never advance, so it degrades to 1.
  assign step = (stride_q == 8'd0) ? 32'd1 : {24'd0, stride_q};
`else
  assign step = 32'd1;
`endif

  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    drain_d = drain_q;
    valid_d = 1'b0;
    m04_d   = m04_q;
    busy_d  = busy_q;
    done_d  = done_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
`ifdef NONCE_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          hi_d    = m04_hi;
          nonce_d = nonce_start;
          rem_d   = nonce_end - nonce_start;
          cnt_d   = 32'd0;
          hit_d   = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef NONCE_STRIDE_EN
          stride_d = stride;
`endif
        end
      end
      S_RUN: begin
        if (found) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hit_d   = 1'b1;
        end else begin
          valid_d = 1'b1;
          m04_d   = {hi_q, nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
          cnt_d   = cnt_q + 32'd1;
          // remaining counts nonces left after this one, so full range needs no 33rd bit
          if (rem_q < step) begin
            state_d = S_DRAIN;
            drain_d = DW'(PIPE_LAT);
          end else begin
            nonce_d = nonce_q + step;
            rem_d   = rem_q - step;
          end
        end
      end
      S_DRAIN: begin
        if (found || drain_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hit_d   = found;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hit_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nonce_q <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      drain_q <= '0;
      valid_q <= 1'b0;
      m04_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef NONCE_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      drain_q <= drain_d;
      valid_q <= valid_d;
      m04_q   <= m04_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
`ifdef NONCE_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  assign valid    = valid_q;
  assign m04      = m04_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hit      = hit_q;
  assign hash_cnt = cnt_q;

endmodule

// File: tb/tb_nonce_dispatch.sv
// Self-checking bench for nonce_dispatch: directed plan cases plus random jobs
// checked against an arithmetic nonce-list model.
module tb_nonce_dispatch;
  localparam int PIPE_LAT = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] m04_hi = '0;
  logic [31:0] nonce_start = '0;
  logic [31:0] nonce_end = '0;
  logic [7:0]  stride = 8'd1;
  logic        found = 1'b0;
  logic        valid;
  logic [63:0] m04;
  logic        busy;
  logic        done;
  logic        hit;
  logic [31:0] hash_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int step_m = 1;

  nonce_dispatch #(.PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .m04_hi(m04_hi), .nonce_start(nonce_start), .nonce_end(nonce_end),
`ifdef NONCE_STRIDE_EN
    .stride(stride),
`endif
    .found(found), .valid(valid), .m04(m04), .busy(busy), .done(done),
    .hit(hit), .hash_cnt(hash_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // f: issue index at which found is sampled (0 = never); restart_at: issue
  // after which a stray start is pulsed during RUN (0 = never).
  task automatic run_job(input string nm, input logic [31:0] hi, input logic [31:0] s,
                         input logic [31:0] e, input int f, input int restart_at);
    logic [31:0] exp_q[$];
    logic [31:0] span;
    int n, lim;
    span = e - s;
    n = int'(longint'(span) / longint'(step_m)) + 1;
    for (int k = 0; k < n; k++) exp_q.push_back(s + 32'(longint'(k) * longint'(step_m)));
    lim = (f != 0) ? f - 1 : n;
    @(negedge clk);
    m04_hi = hi; nonce_start = s; nonce_end = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0; found = (f == 1);
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL %s start_latency valid=%b busy=%b exp valid=0 busy=1", nm, valid, busy); end
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      found = 1'b0; start = 1'b0;
      n_cmp++; if (valid !== 1'b1) begin n_bad++;
        $display("FAIL %s issue_valid k=%0d got=%b exp=1", nm, k, valid); end
      n_cmp++; if (m04 !== {hi, bswap(exp_q[k-1])}) begin n_bad++;
        $display("FAIL %s issue_m04 k=%0d got=%h exp=%h", nm, k, m04, {hi, bswap(exp_q[k-1])}); end
      n_cmp++; if (hash_cnt !== 32'(k)) begin n_bad++;
        $display("FAIL %s issue_cnt k=%0d got=%0d exp=%0d", nm, k, hash_cnt, k); end
      if (f == k + 1) found = 1'b1;
      if (restart_at == k) begin start = 1'b1; nonce_start = s + 32'h1000; m04_hi = ~hi; end
    end
    if (f != 0) begin
      @(negedge clk);
      found = 1'b0; start = 1'b0;
      n_cmp++; if (valid !== 1'b0 || done !== 1'b1 || hit !== 1'b1 || busy !== 1'b0) begin n_bad++;
        $display("FAIL %s found_term valid=%b done=%b hit=%b busy=%b exp 0/1/1/0", nm, valid, done, hit, busy); end
      n_cmp++; if (hash_cnt !== 32'(f - 1)) begin n_bad++;
        $display("FAIL %s found_cnt got=%0d exp=%0d", nm, hash_cnt, f - 1); end
    end else begin
      for (int d = 1; d <= PIPE_LAT + 1; d++) begin
        @(negedge clk);
        start = 1'b0;
        if (d <= PIPE_LAT) begin
          n_cmp++; if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin n_bad++;
            $display("FAIL %s drain d=%0d valid=%b done=%b busy=%b exp 0/0/1", nm, d, valid, done, busy); end
        end else begin
          n_cmp++; if (valid !== 1'b0 || done !== 1'b1 || hit !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL %s exhaust valid=%b done=%b hit=%b busy=%b exp 0/1/0/0", nm, valid, done, hit, busy); end
          n_cmp++; if (hash_cnt !== 32'(n)) begin n_bad++;
            $display("FAIL %s exhaust_cnt got=%0d exp=%0d", nm, hash_cnt, n); end
          n_cmp++; if (m04 !== {hi, bswap(exp_q[n-1])}) begin n_bad++;
            $display("FAIL %s m04_hold got=%h exp=%h", nm, m04, {hi, bswap(exp_q[n-1])}); end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({valid, m04, busy, done, hit, hash_cnt} !== '0) begin n_bad++;
      $display("FAIL reset_values valid=%b m04=%h busy=%b done=%b hit=%b cnt=%0d exp all 0",
               valid, m04, busy, done, hit, hash_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_exhaust();
    run_job("exhaust", 32'hA5A5_0001, 32'h10, 32'h13, 0, 0);
    @(negedge clk); found = 1'b1;
    @(negedge clk); found = 1'b0;
    n_cmp++; if (done !== 1'b1 || hit !== 1'b0) begin n_bad++;
      $display("FAIL found_in_done done=%b hit=%b exp 1/0", done, hit); end
  endtask

  task automatic test_found();
    run_job("found10", 32'h1234_5678, 32'h0, 32'hFFFF, 10, 0);
    run_job("found_first", 32'h0, 32'h40, 32'h4F, 1, 0);
    run_job("found_on_last", 32'h1, 32'h80, 32'h83, 4, 0);
  endtask

  task automatic test_wrap();
    run_job("wrap", 32'hDEAD_BEEF, 32'hFFFF_FFFE, 32'h1, 0, 0);
    run_job("single", 32'hCAFE_0000, 32'h55, 32'h55, 0, 0);
  endtask

  task automatic test_abort_and_restart();
    run_job("start_in_run", 32'h7777_0000, 32'h20, 32'h27, 0, 2);
    @(negedge clk);
    m04_hi = 32'h1; nonce_start = 32'h100; nonce_end = 32'h1FF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1; found = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; found = 1'b0; start = 1'b0;
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0) begin n_bad++;
      $display("FAIL abort valid=%b busy=%b done=%b hit=%b exp all 0", valid, busy, done, hit); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL abort_idle valid=%b busy=%b exp 0/0", valid, busy); end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    m04_hi = 32'hFFFF_FFFF; nonce_start = 32'h10; nonce_end = 32'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin n_bad++;
      $display("FAIL pre_reset_drain busy=%b valid=%b exp 1/0", busy, valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if ({valid, m04, busy, done, hit, hash_cnt} !== '0) begin n_bad++;
      $display("FAIL reset_mid_drain valid=%b m04=%h busy=%b done=%b hit=%b cnt=%0d exp all 0",
               valid, m04, busy, done, hit, hash_cnt); end
    repeat (PIPE_LAT + 2) @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_discard done=%b busy=%b exp 0/0", done, busy); end
    run_job("after_reset", 32'h0BAD_F00D, 32'h300, 32'h302, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] s;
      int len, f;
      s = (i % 3 == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
      len = $urandom_range(1, 20);
      f = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len) : 0;
      run_job("random", $urandom, s, s + 32'(len - 1), f, 0);
    end
  endtask

`ifdef NONCE_STRIDE_EN
  task automatic test_stride();
    stride = 8'd4; step_m = 4;
    run_job("stride4", 32'h5, 32'd2, 32'd13, 0, 0);
    stride = 8'd0; step_m = 1;
    run_job("stride0", 32'h6, 32'd7, 32'd10, 0, 0);
    stride = 8'd1; step_m = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_exhaust();
    test_found();
    test_wrap();
    test_abort_and_restart();
    test_reset_mid_drain();
    test_random();
`ifdef NONCE_STRIDE_EN
    test_stride();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
